// File: rtl/demux_stream_router_pkg.sv
// -----------------------------------------------------------------------------
// demux_stream_router_pkg
//   Shared definitions for the 1-to-N stream demultiplexer:
//     - default data width and port count
//     - width of the saturating drop counter
//     - per-port slot state encoding
//     - helper that sizes the destination select for a given port count
// -----------------------------------------------------------------------------
package demux_stream_router_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_OUT = 2;
    localparam int DROP_CNT_W    = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Number of select bits needed to address n ports. At least one bit so a
    // degenerate port count still yields a legal vector width.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_stream_router_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
//   One-entry output register for a single demux port.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset (slot becomes EMPTY, data 0)
//     fill       load fill_data this cycle (only asserted when can_accept)
//     fill_data  word to load
//     out_ready  consumer takes the held word this cycle
//     valid      slot holds a word
//     data       held word (keeps its last value while empty)
//     can_accept slot can take a new word this cycle
// -----------------------------------------------------------------------------
module demux_slot
    import demux_stream_router_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    slot_state_e      state_reg;
    logic [WIDTH-1:0] data_reg;

    assign valid = (state_reg == SLOT_FULL);
    assign data  = data_reg;

    // A full slot that is being drained this cycle can be refilled in the
    // same cycle, which is what lets a port sustain one word per clock.
    assign can_accept = (state_reg == SLOT_EMPTY) || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SLOT_EMPTY;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                SLOT_EMPTY: begin
                    if (fill) begin
                        state_reg <= SLOT_FULL;
                        data_reg  <= fill_data;
                    end
                end
                SLOT_FULL: begin
                    // Drain-then-fill: a simultaneous fill replaces the word.
                    if (fill) begin
                        data_reg <= fill_data;
                    end else if (out_ready) begin
                        state_reg <= SLOT_EMPTY;
                    end
                end
                default: begin
                    state_reg <= SLOT_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/demux_stream_router.sv
// -----------------------------------------------------------------------------
// demux_stream_router
//   Registered 1-to-N stream demultiplexer with valid/ready handshakes. Each
//   input word is routed to exactly one output port chosen by in_sel; every
//   port has a one-entry output register so consumers can stall independently.
//   Words addressed to a non-existent port are accepted and discarded.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     in_valid      input word present
//     in_ready      block accepts the word this cycle (combinational)
//     in_data       input word
//     in_sel        destination port index
//     out_valid[k]  port k holds a word
//     out_ready[k]  consumer k takes the word this cycle
//     out_data      port k data at [k*WIDTH +: WIDTH]
//     sel_err       one-cycle pulse per dropped (out-of-range) word
//     drop_cnt      saturating count of dropped words
// -----------------------------------------------------------------------------
module demux_stream_router
    import demux_stream_router_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_OUT = DEFAULT_N_OUT,
    parameter int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   sel_err,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int SEL_SPAN = 1 << SEL_W;
    // One extra bit so N_OUT itself is representable when it is a power of two.
    localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W + 1)'(N_OUT);

    logic [N_OUT-1:0]    can_accept;
    logic [N_OUT-1:0]    fill_vec;
    logic [SEL_SPAN-1:0] can_accept_pad;
    logic                sel_in_range;
    logic                in_xfer;
    logic                drop;

    logic                  sel_err_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    assign sel_in_range = ({1'b0, in_sel} < N_OUT_EXT);

    // Pad the per-port accept flags out to every encodable select value so the
    // in_ready mux never indexes past the end of the vector. Padding entries
    // are never used because out-of-range selects take the other mux arm.
    always_comb begin
        can_accept_pad               = '0;
        can_accept_pad[N_OUT-1:0]    = can_accept;
    end

    // Only the addressed port's state participates; other ports stalling has
    // no effect on acceptance.
    assign in_ready = !rst && (sel_in_range ? can_accept_pad[in_sel] : 1'b1);
    assign in_xfer  = in_valid && in_ready;
    assign drop     = in_xfer && !sel_in_range;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
            assign fill_vec[gi] = in_xfer && (in_sel == SEL_W'(gi));

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .fill       (fill_vec[gi]),
                .fill_data  (in_data),
                .out_ready  (out_ready[gi]),
                .valid      (out_valid[gi]),
                .data       (out_data[gi*WIDTH +: WIDTH]),
                .can_accept (can_accept[gi])
            );
        end
    endgenerate

    // Drop reporting: sel_err mirrors the previous cycle's drop, so a run of
    // consecutive drops keeps it high continuously.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_reg  <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            sel_err_reg <= drop;
            if (drop && (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign sel_err  = sel_err_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: doc/demux_stream_router.md
# demux_stream_router

Registered 1-to-N stream demultiplexer with valid/ready handshakes. It is the distribution counterpart of the 2:1 selection mux used in the barrel-shifter datapath: one input stream carries a data word and a destination select, and each word is delivered to exactly one of N output ports. Each port has a one-entry output register. The block sits between the shifter front end and per-lane consumers that may stall independently.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- N_OUT, 2, number of output ports (2..16)
- SEL_W, $clog2(N_OUT), width of the destination select

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  SEL_W  destination port index
- out_valid  output  N_OUT  bit k: port k holds a word
- out_ready  input  N_OUT  bit k: consumer k takes the word this cycle
- out_data  output  N_OUT*WIDTH  port k data is bits [k*WIDTH +: WIDTH]
- sel_err  output  1  one-cycle pulse: a word with in_sel ≥ N_OUT was dropped
- drop_cnt  output  8  saturating count of dropped words

## Operation
- Transfer rule: an input transfer occurs when in_valid && in_ready. An output transfer on port k occurs when out_valid[k] && out_ready[k].
- Per-port slot states: EMPTY and FULL. Transitions:
  - EMPTY → FULL on an input transfer targeting port k.
  - FULL → EMPTY on an output drain with no simultaneous fill.
  - FULL → FULL on a simultaneous drain and fill. The new word replaces the old word, so a port sustains one word per cycle.
- in_ready is combinational:
  - if in_sel < N_OUT: in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel])
  - if in_sel ≥ N_OUT: in_ready = !rst
- Out-of-range select (reachable only when N_OUT is not a power of two):
  - The word is accepted and discarded.
  - sel_err pulses on the next cycle.
  - drop_cnt increments and saturates at 255.
- in_ready never depends on the state of any port other than in_sel.
- While out_valid[k] is high and out_ready[k] is low, out_data[k] stays stable.
- out_data for an empty port holds its last value. Consumers ignore it.
- Reset values: out_valid = 0, out_data = 0, sel_err = 0, drop_cnt = 0, all slots EMPTY. in_ready is 0 while rst is high.
- Reset mid-operation: all buffered words are discarded. The input is not accepted in the reset cycle.

## Timing
- Latency: a word accepted at edge n is visible on out_valid/out_data after edge n (one cycle). There is no combinational path from in_data to out_data.
- Throughput: one word per cycle in aggregate. With out_ready held high on the target port, back-to-back accepts are sustained.
- Combinational paths: in_ready depends on in_sel, out_ready and slot state. No other combinational input-to-output path exists.
- Simultaneous events:
  - Drain of port j and fill of port k (j≠k) in the same cycle both take effect.
  - Drain and fill of the same port in the same cycle take effect as drain then fill.
- sel_err is registered. It is high for exactly one cycle per dropped word, so consecutive drops keep it high continuously.

## Structure
- Shared package: SEL_W computation function and the default WIDTH/N_OUT constants.
- Sub-module demux_slot: one-entry register with fill, data, out_ready inputs and valid, data, can_accept outputs. The top instantiates N_OUT copies in a generate loop and adds select decode, in_ready mux and drop logic.
- Target size: 150–250 lines of RTL in total.

## Test plan
- Reset: assert rst for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, drop_cnt=0. First accept happens only on the first cycle after rst deasserts.
- Basic routing (N_OUT=2): send 0xA5 with sel=1, then 0x3C with sel=0, out_ready=2'b11 → out_valid=2'b10 with port 1 = 0xA5 one cycle after the first accept, then port 0 = 0x3C on the next cycle. No loss, no duplication.
- Backpressure: port 0 out_ready=0 with slot full, offer sel=0 → in_ready=0 and out_data[0] is held. Same cycle, offer sel=1 → accepted. Release out_ready[0] → in_ready=1 that cycle.
- Pass-through at full rate: 16 consecutive words 0x00..0x0F to port 1 with out_ready[1]=1 → in_ready stays 1 throughout, and the port 1 output sequence matches the input exactly.
- Invalid select (N_OUT=3): send 5 words with sel=3 → every out_valid stays 0, sel_err is high for 5 cycles, drop_cnt=5. Then send 300 such words → drop_cnt=255.
- Reset mid-operation: fill both ports, pulse rst for 1 cycle → out_valid=0 and the held words are never delivered.
